// File: rtl/clint_timer_if.sv
// Register-bus bundle between the AXI-to-reg bridge (master) and the CLINT (slave).
// Single-cycle request, response one cycle later; the slave never stalls.
interface clint_timer_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  req_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [31:0]           wdata_i;
  logic [3:0]            be_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [31:0]           rdata_o;
  logic                  err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/clint_timer.sv
// CLINT: 64-bit mtime with prescaled/external/test tick, per-hart mtimecmp and msip.
// Bus always granted, response one cycle after the request; IRQ one cycle after the compare holds.
module clint_timer #(
  parameter int NR_CORES    = 1,
  parameter int ADDR_WIDTH  = 16,
  parameter int USE_EXT_RTC = 0,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                testmode_i,
  input  logic                rtc_i,
  clint_timer_if.slave        bus,
  output logic [NR_CORES-1:0] timer_irq_o,
  output logic [NR_CORES-1:0] ipi_o
);

  localparam logic [12:0] NC = 13'(NR_CORES);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          cmp_q [NR_CORES];
  logic [63:0]          cmp_d [NR_CORES];
  logic [NR_CORES-1:0]  msip_q, msip_d;
  logic [NR_CORES-1:0]  irq_q, irq_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [2:0]           rtc_sync_q;
  logic                 ext_tick_q;
  logic                 rvalid_q, err_q, err_d;
  logic [31:0]          rdata_q, rdata_d;

  logic [15:0] off, cmp_off;
  logic [11:0] msip_idx, cmp_idx;
  logic        hi_zero, msip_hit, cmp_hit, div_hit, mtime_hit, hit;
  logic        wr, rd, tick, pcnt_tick;
  logic [31:0] mask, div_ext;
  logic        unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [31:0] m);
    return (old & ~m) | (nw & m);
  endfunction

  // Hart indices are range-checked here so out-of-range harts fall through to the error path
  assign off       = bus.addr_i[15:0];
  assign cmp_off   = off - 16'h4000;
  assign msip_idx  = off[13:2];
  assign cmp_idx   = cmp_off[14:3];
  assign hi_zero   = ((bus.addr_i >> 16) == '0);
  assign msip_hit  = hi_zero && (off[15:14] == 2'b00) && ({1'b0, msip_idx} < NC);
  assign cmp_hit   = hi_zero && (off >= 16'h4000) && (off < 16'hBFF0) && ({1'b0, cmp_idx} < NC);
  assign div_hit   = hi_zero && (off[15:2] == 14'h2FFC);
  assign mtime_hit = hi_zero && (off[15:3] == 13'h17FF);
  assign hit       = msip_hit | cmp_hit | div_hit | mtime_hit;
  assign wr        = bus.req_i & bus.we_i & (|bus.be_i);
  assign rd        = bus.req_i & ~bus.we_i;
  assign mask      = {{8{bus.be_i[3]}}, {8{bus.be_i[2]}}, {8{bus.be_i[1]}}, {8{bus.be_i[0]}}};
  assign div_ext   = 32'(div_q);
  assign unused_bits = ^{off[1:0], cmp_off[2:0], cmp_off[15]};

  assign pcnt_tick = (pcnt_q == div_q);
  assign tick      = testmode_i | ((USE_EXT_RTC != 0) ? ext_tick_q : pcnt_tick);

  always_comb begin
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    cmp_d   = cmp_q;
    msip_d  = msip_q;
    div_d   = div_q;
    pcnt_d  = pcnt_tick ? '0 : pcnt_q + DIV_ONE;
    rdata_d = '0;
    err_d   = bus.req_i & ~hit;

    if (wr) begin
      for (int i = 0; i < NR_CORES; i++) begin
        if (msip_hit && msip_idx == 12'(i) && bus.be_i[0]) msip_d[i] = bus.wdata_i[0];
        if (cmp_hit && cmp_idx == 12'(i)) begin
          if (off[2]) cmp_d[i][63:32] = merge(cmp_q[i][63:32], bus.wdata_i, mask);
          else        cmp_d[i][31:0]  = merge(cmp_q[i][31:0],  bus.wdata_i, mask);
        end
      end
      if (div_hit) begin
        div_d  = DIV_WIDTH'(merge(div_ext, bus.wdata_i, mask));
        pcnt_d = '0;
      end
      // A concurrent tick is dropped: both words start from the pre-tick value
      if (mtime_hit) begin
        if (off[2]) mtime_d = {merge(mtime_q[63:32], bus.wdata_i, mask), mtime_q[31:0]};
        else        mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], bus.wdata_i, mask)};
      end
    end

    if (rd) begin
      for (int i = 0; i < NR_CORES; i++) begin
        if (msip_hit && msip_idx == 12'(i)) rdata_d = {31'b0, msip_q[i]};
        if (cmp_hit && cmp_idx == 12'(i))   rdata_d = off[2] ? cmp_q[i][63:32] : cmp_q[i][31:0];
      end
      if (div_hit)   rdata_d = div_ext;
      if (mtime_hit) rdata_d = off[2] ? mtime_q[63:32] : mtime_q[31:0];
    end

    for (int i = 0; i < NR_CORES; i++) irq_d[i] = (mtime_q >= cmp_q[i]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      for (int i = 0; i < NR_CORES; i++) cmp_q[i] <= '1;
      msip_q     <= '0;
      irq_q      <= '0;
      div_q      <= DIV_ONE;
      pcnt_q     <= '0;
      rtc_sync_q <= '0;
      ext_tick_q <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
      msip_q     <= msip_d;
      irq_q      <= irq_d;
      div_q      <= div_d;
      pcnt_q     <= pcnt_d;
      rtc_sync_q <= {rtc_sync_q[1:0], rtc_i};
      ext_tick_q <= rtc_sync_q[1] & ~rtc_sync_q[2];
      rvalid_q   <= bus.req_i;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.gnt_o    = 1'b1;
  assign bus.rvalid_o = rvalid_q;
  assign bus.err_o    = err_q;
  assign bus.rdata_o  = rdata_q;
  assign timer_irq_o  = irq_q;
  assign ipi_o        = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench: internal-prescaler CLINT with two harts plus an external-RTC single-hart CLINT.
module tb_clint_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       tm0, tm1, rtc0, rtc1;
  logic [1:0] irq0, ipi0;
  logic [0:0] irq1, ipi1;

  clint_timer_if #(.ADDR_WIDTH(16)) bus0 ();
  clint_timer_if #(.ADDR_WIDTH(16)) bus1 ();

  clint_timer #(.NR_CORES(2), .ADDR_WIDTH(16), .USE_EXT_RTC(0), .DIV_WIDTH(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .testmode_i(tm0), .rtc_i(rtc0), .bus(bus0),
    .timer_irq_o(irq0), .ipi_o(ipi0)
  );

  clint_timer #(.NR_CORES(1), .ADDR_WIDTH(16), .USE_EXT_RTC(1), .DIV_WIDTH(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .testmode_i(tm1), .rtc_i(rtc1), .bus(bus1),
    .timer_irq_o(irq1), .ipi_o(ipi1)
  );

  int          errors = 0;
  int          checks = 0;
  logic        rsp_vld, rsp_err;
  logic [31:0] rsp_dat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge with the response captured
  task automatic bus_op(input bit sel, input logic we, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
    if (!sel) begin
      bus0.req_i = 1'b1; bus0.we_i = we; bus0.addr_i = addr; bus0.wdata_i = wd; bus0.be_i = be;
    end else begin
      bus1.req_i = 1'b1; bus1.we_i = we; bus1.addr_i = addr; bus1.wdata_i = wd; bus1.be_i = be;
    end
    @(posedge clk);
    #1;
    bus0.req_i = 1'b0;
    bus1.req_i = 1'b0;
    rsp_vld = sel ? bus1.rvalid_o : bus0.rvalid_o;
    rsp_err = sel ? bus1.err_o    : bus0.err_o;
    rsp_dat = sel ? bus1.rdata_o  : bus0.rdata_o;
  endtask

  task automatic wr(input bit sel, input logic [15:0] addr, input logic [31:0] wd,
                    input logic [3:0] be);
    bus_op(sel, 1'b1, addr, wd, be);
  endtask

  task automatic rd(input bit sel, input logic [15:0] addr);
    bus_op(sel, 1'b0, addr, 32'h0, 4'h0);
  endtask

  initial begin
    rst = 1'b1; tm0 = 1'b0; tm1 = 1'b0; rtc0 = 1'b0; rtc1 = 1'b0;
    bus0.req_i = 1'b0; bus0.we_i = 1'b0; bus0.addr_i = '0; bus0.wdata_i = '0; bus0.be_i = '0;
    bus1.req_i = 1'b0; bus1.we_i = 1'b0; bus1.addr_i = '0; bus1.wdata_i = '0; bus1.be_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq",    irq0, 2'b00);
    chk("rst_ipi",    ipi0, 2'b00);
    chk("rst_rvalid", bus0.rvalid_o, 1'b0);
    chk("rst_err",    bus0.err_o, 1'b0);
    chk("rst_rdata",  bus0.rdata_o, 32'h0);
    chk("gnt",        bus0.gnt_o, 1'b1);
    rst = 1'b0;

    // Idle 20 cycles at div=1: one tick per two cycles
    repeat (20) @(posedge clk);
    #1;
    chk("idle_irq", irq0, 2'b00);
    chk("idle_ipi", ipi0, 2'b00);
    rd(0, 16'hBFF8);
    chk("idle_mtime_vld", rsp_vld, 1'b1);
    chk("idle_mtime_err", rsp_err, 1'b0);
    chk("idle_mtime_lo",  rsp_dat, 32'd10);
    rd(0, 16'hBFF0);
    chk("div_reset", rsp_dat, 32'd1);

    // msip of the last hart
    wr(0, 16'h0004, 32'hFFFF_FFFF, 4'hF);
    chk("msip_set_ipi",  ipi0, 2'b10);
    chk("msip_wr_err",   rsp_err, 1'b0);
    chk("msip_wr_rdata", rsp_dat, 32'h0);
    rd(0, 16'h0004);
    chk("msip1_read", rsp_dat, 32'd1);
    rd(0, 16'h0000);
    chk("msip0_read", rsp_dat, 32'd0);
    wr(0, 16'h0004, 32'h0, 4'hF);
    chk("msip_clr_ipi", ipi0, 2'b00);
    wr(0, 16'h0000, 32'h1, 4'h0);
    chk("be0_err", rsp_err, 1'b0);
    chk("be0_ipi", ipi0, 2'b00);

    // Unmapped addresses
    rd(0, 16'h8000);
    chk("unm8000_vld", rsp_vld, 1'b1);
    chk("unm8000_err", rsp_err, 1'b1);
    chk("unm8000_dat", rsp_dat, 32'h0);
    rd(0, 16'h0008);
    chk("unm_msip_err", rsp_err, 1'b1);
    chk("unm_msip_dat", rsp_dat, 32'h0);
    wr(0, 16'h0008, 32'hFFFF_FFFF, 4'hF);
    chk("unm_wr_err", rsp_err, 1'b1);
    chk("unm_wr_ipi", ipi0, 2'b00);
    rd(0, 16'hBFF4);
    chk("unm_bff4_err", rsp_err, 1'b1);
    rd(0, 16'hBFF0);
    chk("div_unchanged", rsp_dat, 32'd1);

    // Timer compare with div=0
    wr(0, 16'hBFF0, 32'h0, 4'hF);
    wr(0, 16'h4000, 32'd5, 4'hF);
    wr(0, 16'hBFF8, 32'h0, 4'hF);
    wr(0, 16'h4004, 32'h0, 4'hF);
    chk("cmp_irq_early", irq0[0], 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("cmp_irq_at_eq", irq0[0], 1'b0);
    @(posedge clk);
    #1;
    chk("cmp_irq_rise", irq0[0], 1'b1);
    chk("cmp_irq_hart1", irq0[1], 1'b0);
    wr(0, 16'h4004, 32'h1, 4'hF);
    chk("cmp_irq_hold", irq0[0], 1'b1);
    @(posedge clk);
    #1;
    chk("cmp_irq_drop", irq0[0], 1'b0);

    // mtime carry and write-vs-tick collision
    wr(0, 16'hBFFC, 32'h0, 4'hF);
    wr(0, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk);
    #1;
    rd(0, 16'hBFF8);
    chk("wrap_lo", rsp_dat, 32'h0);
    rd(0, 16'hBFFC);
    chk("wrap_hi", rsp_dat, 32'h1);
    wr(0, 16'hBFF8, 32'h1234, 4'hF);
    rd(0, 16'hBFF8);
    chk("coll_lo", rsp_dat, 32'h1234);
    chk("coll_irq", irq0[0], 1'b1);
    wr(0, 16'hBFF8, 32'hAABB_CCDD, 4'b0010);
    rd(0, 16'hBFF8);
    chk("byte_wr_lo", rsp_dat, 32'h0000_CC35);

    // External RTC instance
    rd(1, 16'hBFF8);
    chk("ext_idle", rsp_dat, 32'h0);
    for (int p = 0; p < 5; p++) begin
      rtc1 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rtc1 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end
    repeat (6) @(posedge clk);
    #1;
    rd(1, 16'hBFF8);
    chk("ext_rtc5", rsp_dat, 32'd5);
    tm1 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    tm1 = 1'b0;
    rd(1, 16'hBFF8);
    chk("ext_test15", rsp_dat, 32'd15);
    rd(1, 16'hBFF0);
    chk("ext_div", rsp_dat, 32'd1);
    chk("ext_irq", irq1, 1'b0);
    chk("ext_ipi", ipi1, 1'b0);

    // Asynchronous reset mid-operation
    wr(0, 16'h0000, 32'h1, 4'hF);
    chk("pre_rst_ipi", ipi0, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ipi",    ipi0, 2'b00);
    chk("arst_irq",    irq0, 2'b00);
    chk("arst_rvalid", bus0.rvalid_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
